// File: rtl/inst_fetch.sv
// Instruction fetch front end: issues one word-aligned memory request at a time,
// holds the returned word for decode, and follows redirects by killing stale responses.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        inst_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    // state   | meaning
    // S_IDLE  | one cycle after reset release, all inputs ignored
    // S_REQ   | request at pc presented, waiting for imem_ready_i
    // S_WAIT  | request accepted, waiting for imem_rvalid_i (kill_q drops it)
    // S_VALID | instruction held for decode, waiting for inst_ready_i
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] target;

    assign target = redirect_pc_i & 32'hFFFF_FFFC;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect_i) begin
                    pc_d = target;
                end
                // The accepted request carries the old address, so its response must die.
                if (imem_ready_i) begin
                    state_d = S_WAIT;
                    kill_d  = redirect_i;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_i || kill_q) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d   = S_VALID;
                        inst_d    = imem_rdata_i;
                        inst_pc_d = pc_q;
                    end
                    if (redirect_i) begin
                        pc_d = target;
                    end
                end else if (redirect_i) begin
                    pc_d   = target;
                    kill_d = 1'b1;
                end
            end
            S_VALID: begin
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (inst_ready_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_o   = (state_q == S_REQ);
    assign imem_addr_o  = pc_q;
    assign inst_valid_o = (state_q == S_VALID);
    assign inst_o       = inst_q;
    assign pc_o         = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a directed per-cycle vector table, an async-reset sequence,
// and a randomized run against a transaction-level fetch model.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, inst_ready, redirect;
    logic [31:0] inst, pc, redirect_pc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .imem_req_o(imem_req),
        .imem_addr_o(imem_addr),
        .imem_ready_i(imem_ready),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i(imem_rdata),
        .inst_valid_o(inst_valid),
        .inst_o(inst),
        .pc_o(pc),
        .inst_ready_i(inst_ready),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc)
    );

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        iready;
        logic        redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einst;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic ir, logic rdr,
                                logic [31:0] rp, logic eq, logic [31:0] ea, logic ev,
                                logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.ready = rdy; v.rvalid = rv; v.rdata = rd; v.iready = ir; v.redir = rdr; v.rpc = rp;
        v.ereq = eq; v.eaddr = ea; v.evalid = ev; v.einst = ei; v.epc = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic eq, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, eq});
        chk({tag, ".addr"}, imem_addr, ea);
        chk({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, ev});
        chk({tag, ".inst"}, inst, ei);
        chk({tag, ".pc"}, pc, ep);
    endtask

    task automatic idle_inputs();
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 32'h0;
        inst_ready = 0; redirect = 0; redirect_pc = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Transaction-level reference: tracks whether the fetcher has started, whether a
    // request is in flight (and doomed), and whether an instruction is held.
    bit          m_started, m_inflight, m_doomed, m_holding;
    logic [31:0] m_pc, m_inst, m_inst_pc;

    task automatic model_reset();
        m_started = 0; m_inflight = 0; m_doomed = 0; m_holding = 0;
        m_pc = RST_PC; m_inst = 32'h0; m_inst_pc = RST_PC;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (!m_started) begin
            m_started = 1;
        end else if (m_holding) begin
            if (redirect) begin
                m_holding = 0; m_pc = tgt;
            end else if (inst_ready) begin
                m_holding = 0; m_pc = m_pc + 32'd4;
            end
        end else if (m_inflight) begin
            if (imem_rvalid) begin
                m_inflight = 0;
                if (!redirect && !m_doomed) begin
                    m_holding = 1; m_inst = imem_rdata; m_inst_pc = m_pc;
                end
                m_doomed = 0;
                if (redirect) m_pc = tgt;
            end else if (redirect) begin
                m_doomed = 1; m_pc = tgt;
            end
        end else begin
            if (imem_ready) begin
                m_inflight = 1; m_doomed = redirect;
            end
            if (redirect) m_pc = tgt;
        end
    endtask

    initial begin
        tbl[0]  = mk(0,1,32'h1111_1111,0,1,32'h0000_1234, 0,32'h8000_0000,0,32'h0,         32'h8000_0000);
        tbl[1]  = mk(1,0,32'h0,        0,0,32'h0,         1,32'h8000_0000,0,32'h0,         32'h8000_0000);
        tbl[2]  = mk(0,1,32'hA000_0000,0,0,32'h0,         0,32'h8000_0000,0,32'h0,         32'h8000_0000);
        tbl[3]  = mk(0,0,32'h0,        1,0,32'h0,         0,32'h8000_0000,1,32'hA000_0000, 32'h8000_0000);
        tbl[4]  = mk(1,0,32'h0,        0,0,32'h0,         1,32'h8000_0004,0,32'hA000_0000, 32'h8000_0000);
        tbl[5]  = mk(0,1,32'hA000_0001,0,0,32'h0,         0,32'h8000_0004,0,32'hA000_0000, 32'h8000_0000);
        tbl[6]  = mk(0,0,32'h0,        0,0,32'h0,         0,32'h8000_0004,1,32'hA000_0001, 32'h8000_0004);
        tbl[7]  = mk(1,1,32'hFFFF_FFFF,0,0,32'h0,         0,32'h8000_0004,1,32'hA000_0001, 32'h8000_0004);
        tbl[8]  = mk(0,0,32'h0,        1,0,32'h0,         0,32'h8000_0004,1,32'hA000_0001, 32'h8000_0004);
        tbl[9]  = mk(0,0,32'h0,        0,0,32'h0,         1,32'h8000_0008,0,32'hA000_0001, 32'h8000_0004);
        tbl[10] = mk(0,0,32'h0,        0,1,32'h8000_0101, 1,32'h8000_0008,0,32'hA000_0001, 32'h8000_0004);
        tbl[11] = mk(1,0,32'h0,        0,1,32'h8000_0200, 1,32'h8000_0100,0,32'hA000_0001, 32'h8000_0004);
        tbl[12] = mk(0,1,32'hBAD0_0000,0,0,32'h0,         0,32'h8000_0200,0,32'hA000_0001, 32'h8000_0004);
        tbl[13] = mk(1,0,32'h0,        0,0,32'h0,         1,32'h8000_0200,0,32'hA000_0001, 32'h8000_0004);
        tbl[14] = mk(0,0,32'h0,        0,1,32'hFFFF_FFFF, 0,32'h8000_0200,0,32'hA000_0001, 32'h8000_0004);
        tbl[15] = mk(0,0,32'h0,        0,0,32'h0,         0,32'hFFFF_FFFC,0,32'hA000_0001, 32'h8000_0004);
        tbl[16] = mk(0,1,32'hBAD0_0002,0,0,32'h0,         0,32'hFFFF_FFFC,0,32'hA000_0001, 32'h8000_0004);
        tbl[17] = mk(1,0,32'h0,        0,0,32'h0,         1,32'hFFFF_FFFC,0,32'hA000_0001, 32'h8000_0004);
        tbl[18] = mk(0,1,32'hC000_0000,0,0,32'h0,         0,32'hFFFF_FFFC,0,32'hA000_0001, 32'h8000_0004);
        tbl[19] = mk(0,0,32'h0,        1,0,32'h0,         0,32'hFFFF_FFFC,1,32'hC000_0000, 32'hFFFF_FFFC);
        tbl[20] = mk(1,0,32'h0,        0,0,32'h0,         1,32'h0000_0000,0,32'hC000_0000, 32'hFFFF_FFFC);
        tbl[21] = mk(0,1,32'hBAD0_0003,0,1,32'h8000_0300, 0,32'h0000_0000,0,32'hC000_0000, 32'hFFFF_FFFC);
        tbl[22] = mk(1,0,32'h0,        0,0,32'h0,         1,32'h8000_0300,0,32'hC000_0000, 32'hFFFF_FFFC);
        tbl[23] = mk(0,1,32'hD000_0000,0,0,32'h0,         0,32'h8000_0300,0,32'hC000_0000, 32'hFFFF_FFFC);
        tbl[24] = mk(0,0,32'h0,        1,1,32'h8000_0203, 0,32'h8000_0300,1,32'hD000_0000, 32'h8000_0300);
        tbl[25] = mk(0,0,32'h0,        0,0,32'h0,         1,32'h8000_0200,0,32'hD000_0000, 32'h8000_0300);

        // Directed table, one row per cycle starting in IDLE.
        do_reset();
        for (int i = 0; i < 26; i++) begin
            chk_all($sformatf("row%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].evalid,
                    tbl[i].einst, tbl[i].epc);
            imem_ready  = tbl[i].ready;
            imem_rvalid = tbl[i].rvalid;
            imem_rdata  = tbl[i].rdata;
            inst_ready  = tbl[i].iready;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            @(posedge clk);
            @(negedge clk);
        end

        // Async reset in the middle of WAIT, stale rvalid across and after release.
        idle_inputs();
        imem_ready = 1;
        @(posedge clk);
        @(negedge clk);
        imem_ready = 0;
        #2 rst_n = 0;
        #1 chk_all("async_rst", 0, RST_PC, 0, 32'h0, RST_PC);
        @(negedge clk);
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        chk_all("rst_idle", 0, RST_PC, 0, 32'h0, RST_PC);
        @(posedge clk);
        @(negedge clk);
        chk_all("rst_req", 1, RST_PC, 0, 32'h0, RST_PC);
        imem_rvalid = 0; imem_ready = 1;
        @(posedge clk);
        @(negedge clk);
        imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013;
        @(posedge clk);
        @(negedge clk);
        chk_all("rst_first", 0, RST_PC, 1, 32'h0000_0013, RST_PC);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            chk_all("rand", m_started && !m_inflight && !m_holding, m_pc, m_holding,
                    m_inst, m_inst_pc);
            imem_ready  = ($urandom_range(0, 99) < 60);
            imem_rvalid = ($urandom_range(0, 99) < 50);
            imem_rdata  = $urandom;
            inst_ready  = ($urandom_range(0, 99) < 60);
            redirect    = ($urandom_range(0, 99) < 12);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                      : $urandom;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req_o  output  1  SHALL be the instruction-memory request valid.
REQ-005 imem_addr_o  output  32  SHALL be the request address, word aligned.
REQ-006 imem_ready_i  input  1  SHALL indicate the memory accepts the request this cycle.
REQ-007 imem_rvalid_i  input  1  SHALL indicate that imem_rdata_i carries the response.
REQ-008 imem_rdata_i  input  32  SHALL be the fetched instruction word.
REQ-009 inst_valid_o  output  1  SHALL indicate that inst_o/pc_o hold an instruction for decode.
REQ-010 inst_o  output  32  SHALL be the instruction presented to the decode stage.
REQ-011 pc_o  output  32  SHALL be the address of inst_o.
REQ-012 inst_ready_i  input  1  SHALL indicate the decode stage consumes inst_o this cycle.
REQ-013 redirect_i  input  1  SHALL request a fetch-stream change (taken branch, jal, jalr).
REQ-014 redirect_pc_i  input  32  SHALL be the redirect target; bits [1:0] are ignored and forced to 0.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, WAIT, VALID. At most one memory request is outstanding.
REQ-016 IDLE SHALL move to REQ on the first clock edge after reset deassertion; no other input acts in IDLE.
REQ-017 REQ: imem_req_o=1, imem_addr_o=pc; on imem_ready_i go to WAIT. Without imem_ready_i, hold the address stable.
REQ-018 WAIT: on imem_rvalid_i, capture imem_rdata_i into inst_o and pc into pc_o, then go to VALID. A response is never dropped unless killed.
REQ-019 VALID: inst_valid_o=1; on inst_ready_i, pc <= pc+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0) and go to REQ.
REQ-020 inst_valid_o SHALL be 1 only in VALID; inst_o/pc_o SHALL stay stable while inst_valid_o=1 and not consumed.
REQ-021 Redirect in REQ without imem_ready_i: pc <= target; stay in REQ. The new address appears on the next cycle.
REQ-022 Redirect in REQ with imem_ready_i the same cycle: pc <= target; go to WAIT with the kill flag set.
REQ-023 Redirect in WAIT: pc <= target; set kill. A killed response SHALL be discarded, and the FSM then clears kill and goes to REQ.
REQ-024 Redirect coincident with imem_rvalid_i in WAIT: discard that response; go to REQ with the target pc.
REQ-025 Redirect in VALID (with or without inst_ready_i): drop the held instruction (inst_valid_o=0 next cycle); pc <= target; go to REQ.
REQ-026 Redirect in IDLE SHALL be ignored.
REQ-027 imem_rvalid_i outside WAIT SHALL be ignored.
REQ-028 Best-case throughput SHALL be one instruction per 3 cycles (REQ, WAIT, VALID), with zero-wait memory and decode always ready.

Reset
REQ-029 Asserting rst_n_i SHALL immediately force the following, regardless of any in-flight transaction:
- state=IDLE
- pc=RESET_PC
- kill=0
- imem_req_o=0
- imem_addr_o=RESET_PC
- inst_valid_o=0
- inst_o=0
- pc_o=RESET_PC
REQ-030 A late imem_rvalid_i arriving after reset SHALL be ignored.

Verification
REQ-031 Reset release, memory always ready, rvalid one cycle after accept, inst_ready_i=1:
-> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 are issued;
-> inst_valid_o pulses every 3rd cycle;
-> pc_o matches each address.
REQ-032 Decode stall: inst_ready_i=0 for 5 cycles in VALID
-> inst_o/pc_o are unchanged and imem_req_o=0 throughout;
-> fetch resumes at pc+4 after acceptance.
REQ-033 Redirect to 0x8000_0100 in WAIT, rvalid arriving 2 cycles later with 0x0000_0013
-> no inst_valid_o;
-> the next request address is 0x8000_0100.
REQ-034 Redirect to 0x8000_0203 in VALID while inst_ready_i=1
-> the held instruction is dropped;
-> the next request address is 0x8000_0200.
REQ-035 Redirect to 0xFFFF_FFFC, then instruction accepted
-> the following request address is 0x0000_0000 (wrap).
REQ-036 rst_n_i asserted mid-WAIT, then released
-> outputs return to reset values asynchronously;
-> a stale rvalid is ignored;
-> fetch restarts at 0x8000_0000.
